// File: rtl/output_memory_manager_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | output_memory_manager_pkg                                             |
// | Shared widths, FSM states and output-region defaults for the vector   |
// | memory managers.                                                      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package output_memory_manager_pkg;

  localparam int ELEM_W = 16;
  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] OUT_BASE_DEFAULT = 9'd256;
  localparam int                OUT_LEN_DEFAULT  = 144;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // Negative two's-complement elements clamp to zero.
  function automatic logic [ELEM_W-1:0] relu(input logic [ELEM_W-1:0] x);
    return x[ELEM_W-1] ? '0 : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_address_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | output_address_counter                                                |
// | Write pointer over [OUT_BASE, OUT_BASE+OUT_LEN) with wrap.            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module output_address_counter
  import output_memory_manager_pkg::*;
#(
  parameter logic [ADDR_W-1:0] OUT_BASE = OUT_BASE_DEFAULT,
  parameter int                OUT_LEN  = OUT_LEN_DEFAULT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              en,
  input  logic              increment,
  output logic [ADDR_W-1:0] address,
  output logic              last_value
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(int'(OUT_BASE) + OUT_LEN - 1);

  logic [ADDR_W-1:0] ptr_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      ptr_q <= OUT_BASE;
    end else if (en && increment) begin
      ptr_q <= (ptr_q == LAST_ADDR) ? OUT_BASE : ptr_q + 1'b1;
    end
  end

  assign address    = ptr_q;
  assign last_value = (ptr_q == LAST_ADDR);

endmodule
`default_nettype wire

// File: rtl/output_memory_manager.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | output_memory_manager                                                 |
// | Serialises 4-element result groups into single memory writes.         |
// | Optional: OUTPUT_RELU_EN clamps negative elements to zero.            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module output_memory_manager
  import output_memory_manager_pkg::*;
#(
  parameter logic [ADDR_W-1:0] OUT_BASE = OUT_BASE_DEFAULT,
  parameter int                OUT_LEN  = OUT_LEN_DEFAULT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              en,
  input  logic              result_valid,
  output logic              result_ready,
  input  logic [ELEM_W-1:0] r0_element,
  input  logic [ELEM_W-1:0] r1_element,
  input  logic [ELEM_W-1:0] r2_element,
  input  logic [ELEM_W-1:0] r3_element,
  output logic [ELEM_W-1:0] output_write_element,
  output logic [ADDR_W-1:0] output_memory_address,
  output logic              memory_enable,
  output logic              memory_write,
  output logic              vector_done
);

  state_e            state_q;
  logic [1:0]        slot_q;
  logic [ELEM_W-1:0] buf_q [4];
  logic [ELEM_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              men_q;
  logic              mwr_q;
  logic              done_q;

  logic              accept;
  logic              issue;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_last;
  logic [ELEM_W-1:0] raw_elem;
  logic [ELEM_W-1:0] wr_elem;

  assign result_ready = (state_q == IDLE) && en && !clear;
  assign accept       = result_valid && result_ready;
  assign issue        = accept || (en && (state_q == WRITE));

  output_address_counter #(
    .OUT_BASE (OUT_BASE),
    .OUT_LEN  (OUT_LEN)
  ) u_addr (
    .clock      (clock),
    .clear      (clear),
    .en         (en),
    .increment  (issue),
    .address    (wr_ptr),
    .last_value (wr_last)
  );

  always_comb begin
    raw_elem = (state_q == IDLE) ? r0_element : buf_q[slot_q];
`ifdef OUTPUT_RELU_EN
    wr_elem = relu(raw_elem);
`else
    wr_elem = raw_elem;
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      men_q   <= 1'b0;
      mwr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      men_q  <= issue;
      mwr_q  <= issue;
      done_q <= issue && wr_last;
      if (issue) begin
        data_q <= wr_elem;
        addr_q <= wr_ptr;
      end else begin
        data_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            buf_q[0] <= r0_element;
            buf_q[1] <= r1_element;
            buf_q[2] <= r2_element;
            buf_q[3] <= r3_element;
            slot_q   <= 2'd1;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          slot_q <= slot_q + 2'd1;
          if (slot_q == 2'd3) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      // Stall: data and address hold, strobes drop.
      men_q  <= 1'b0;
      mwr_q  <= 1'b0;
      done_q <= 1'b0;
    end
  end

  assign output_write_element  = data_q;
  assign output_memory_address = addr_q;
  assign memory_enable         = men_q;
  assign memory_write          = mwr_q;
  assign vector_done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_output_memory_manager.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_output_memory_manager                                              |
// | Scoreboard bench with a queue-based reference model.                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_output_memory_manager;

  localparam int BASE = 256;
  localparam int LEN  = 144;

  typedef struct {
    logic [15:0] data;
    logic [8:0]  addr;
    logic        done;
  } wr_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        en;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] r [4];
  logic [15:0] output_write_element;
  logic [8:0]  output_memory_address;
  logic        memory_enable;
  logic        memory_write;
  logic        vector_done;

  output_memory_manager dut (
    .clock                 (clock),
    .clear                 (clear),
    .en                    (en),
    .result_valid          (result_valid),
    .result_ready          (result_ready),
    .r0_element            (r[0]),
    .r1_element            (r[1]),
    .r2_element            (r[2]),
    .r3_element            (r[3]),
    .output_write_element  (output_write_element),
    .output_memory_address (output_memory_address),
    .memory_enable         (memory_enable),
    .memory_write          (memory_write),
    .vector_done           (vector_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: pending elements of the current group, element index
  // within the output vector, and the values the bus should hold when idle.
  logic [15:0] m_pend [$];
  wr_t         exp_q  [$];
  int          m_idx     = 0;
  logic [15:0] m_data    = '0;
  logic [8:0]  m_addr    = '0;
  bit          m_acc     = 0;
  bit          m_started = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] ref_elem(logic [15:0] x);
`ifdef OUTPUT_RELU_EN
    return ($signed(x) < 0) ? 16'd0 : x;
`else
    return x;
`endif
  endfunction

  function automatic void issue(logic [15:0] x);
    wr_t w;
    w.data = ref_elem(x);
    w.addr = 9'(BASE + m_idx);
    w.done = (m_idx == LEN - 1);
    exp_q.push_back(w);
    m_data = w.data;
    m_addr = w.addr;
    m_idx  = (m_idx + 1) % LEN;
  endfunction

  task automatic tick();
    bit exp_ready;
    #1;
    exp_ready = (m_pend.size() == 0) && en && !clear;
    check("result_ready", 32'(result_ready), 32'(exp_ready));
    @(posedge clock);
    m_acc = 0;
    if (clear) begin
      m_pend.delete();
      m_idx  = 0;
      m_data = '0;
      m_addr = '0;
    end else if (en) begin
      if (m_pend.size() > 0) begin
        issue(m_pend.pop_front());
      end else if (result_valid) begin
        issue(r[0]);
        m_pend.push_back(r[1]);
        m_pend.push_back(r[2]);
        m_pend.push_back(r[3]);
        m_acc = 1;
      end else begin
        m_data = '0;
      end
    end
    m_started = 1;
    @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1; en = 1'b1; result_valid = 1'b1;
    tick();
    clear = 1'b0; result_valid = 1'b0;
  endtask

  task automatic send_group(input logic [15:0] a, b, c, d);
    bit done;
    done = 0;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    result_valid = 1'b1; en = 1'b1; clear = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      tick();
      done = m_acc;
    end
    result_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_group: group not accepted within 16 cycles");
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: compares every bus cycle against the scoreboard.
  always @(negedge clock) begin
    wr_t w;
    if (m_started) begin
      if (memory_enable) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0d data %0h", output_memory_address,
                   output_write_element);
        end else begin
          w = exp_q.pop_front();
          check("wr_data", 32'(output_write_element), 32'(w.data));
          check("wr_addr", 32'(output_memory_address), 32'(w.addr));
          check("wr_done", 32'(vector_done), 32'(w.done));
          check("wr_strobe", 32'(memory_write), 32'd1);
        end
      end else begin
        check("idle_strobes", {30'd0, memory_write, vector_done}, 32'd0);
        check("idle_data", 32'(output_write_element), 32'(m_data));
        check("idle_addr", 32'(output_memory_address), 32'(m_addr));
        if (exp_q.size() != 0) begin
          checks++; errors++;
          $display("FAIL missing_write: expected addr %0d not seen", exp_q[0].addr);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    clear = 1'b1; en = 1'b1; result_valid = 1'b0;
    for (int i = 0; i < 4; i++) r[i] = '0;
    @(negedge clock);
    do_clear();
    check("reset_data", 32'(output_write_element), 32'd0);
    check("reset_addr", 32'(output_memory_address), 32'd0);
    check("reset_men", 32'(memory_enable), 32'd0);

    // Single group.
    send_group(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    idle(5);

    // Back-to-back: full vector plus one group to show the wrap.
    do_clear();
    r[0] = 16'($urandom); r[1] = 16'($urandom); r[2] = 16'($urandom); r[3] = 16'($urandom);
    result_valid = 1'b1;
    for (int g = 0; g < 37; ) begin
      tick();
      if (m_acc) begin
        g++;
        for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
      end
    end
    result_valid = 1'b0;
    idle(5);

    // Stall after r1.
    do_clear();
    send_group(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    tick();
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(5);

    // Clear mid-burst after r1, then a fresh group.
    do_clear();
    send_group(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    send_group(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    idle(5);

    // Sign-boundary group.
    send_group(16'hFFF0, 16'h0005, 16'h8000, 16'h7FFF);
    idle(5);

    // Randomised traffic with stalls, holds and occasional clears.
    result_valid = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      clear = ($urandom_range(0, 59) == 0);
      en    = ($urandom_range(0, 4) != 0);
      if (!result_valid || m_acc || clear) begin
        result_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
      end
      tick();
    end
    clear = 1'b0; en = 1'b1; result_valid = 1'b0;
    idle(8);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_memory_manager.md
Name: output_memory_manager

Overview:
Write-back side of the vector memory interface. Accepts groups of four 16-bit result elements (r0..r3) from the compute lanes over a valid/ready handshake. Serialises each group into single-element writes to the shared vector memory at consecutive addresses in the output region. Signals when a full output vector has been committed.

Parameters:
OUT_BASE, 9'd256, first memory address of the output region.
OUT_LEN, 144, elements per output vector; must be a multiple of 4 and satisfy OUT_BASE+OUT_LEN <= 512.

Ports:
clock  input  1  system clock, all state on posedge.
clear  input  1  synchronous active-high reset.
en  input  1  global enable; 0 stalls the block with all state held.
result_valid  input  1  r0..r3 hold a valid group.
result_ready  output  1  block can accept a group this cycle.
r0_element  input  16  lane 0 result.
r1_element  input  16  lane 1 result.
r2_element  input  16  lane 2 result.
r3_element  input  16  lane 3 result.
output_write_element  output  16  memory write data.
output_memory_address  output  9  memory address.
memory_enable  output  1  memory access strobe.
memory_write  output  1  write strobe.
vector_done  output  1  one-cycle pulse on the last write of a vector.

Behaviour:
- One clock, `clock`. Reset `clear` is synchronous and active-high.
- Reset (clear=1 at a posedge):
  - state=IDLE, slot=0, wr_ptr=OUT_BASE, element count=0.
  - All registered outputs are 0: output_write_element, output_memory_address, memory_enable, memory_write, vector_done.
  - Buffered elements are discarded.
- result_ready is combinational: (state==IDLE) && en && !clear.
- States: IDLE and WRITE; slot is a 2-bit index into the buffer.
- IDLE, result_valid && result_ready at edge E:
  - r0 is registered onto the write outputs at E, with memory_enable=1, memory_write=1 and address=wr_ptr.
  - r1..r3 are stored in the buffer; slot=1; state=WRITE.
  - result_valid while result_ready=0 is ignored; the producer must hold the group.
- WRITE, en=1, each edge:
  - Registers buf[slot] onto output_write_element at address wr_ptr, with strobes=1.
  - slot increments.
  - When slot==3 is issued, state returns to IDLE.
- Latency and throughput:
  - r0 is visible the cycle after the accept edge; r1, r2, r3 follow on consecutive cycles.
  - result_ready is high again in the cycle r3 is on the bus, so back-to-back groups sustain 1 write per cycle (4 cycles per group).
- IDLE with no accept: memory_enable=0, memory_write=0, write data=0, address holds its last value.
- en=0 in any state:
  - No transition and no pointer/slot change.
  - memory_enable=0, memory_write=0; data and address hold.
  - The burst resumes exactly where it stopped once en=1.
- Address pointer:
  - wr_ptr increments by 1 after every issued write.
  - After the write at OUT_BASE+OUT_LEN-1, wr_ptr wraps to OUT_BASE.
  - vector_done=1 in the same cycle as that last write, and 0 otherwise.
- clear mid-burst: remaining buffered elements are dropped with no further writes; the next accepted group starts at OUT_BASE.
- Simultaneous clear and result_valid: clear wins; the group is not accepted.

Optional Feature:
OUTPUT_RELU_EN
- Defined: each element is passed through ReLU before it is registered onto output_write_element. Bit 15 set (negative, two's complement) -> write 16'h0000; otherwise the element is unchanged. Handshake, timing and addresses are unaffected.
- Undefined: elements are written unmodified.

Decomposition:
Shared package holds:
- ELEM_W=16, ADDR_W=9.
- The state enum (IDLE, WRITE).
- Default OUT_BASE/OUT_LEN, shared with input_memory_manager.

One sub-module, output_address_counter:
- Holds wr_ptr with base, length and wrap.
- Inputs: clock, clear, en, increment.
- Outputs: address[8:0], last_value, which drives vector_done.

Test Plan:
- Reset then single group: r0..r3=16'h0011/0022/0033/0044 -> writes on 4 consecutive cycles to addresses 256..259, strobes high, result_ready=0 for 3 cycles then 1.
- Back-to-back: 36 groups with result_valid held high (OUT_LEN=144) -> 144 contiguous writes at 256..399, vector_done pulses only with the write to 399; the next group writes to 256.
- Stall: en=0 for 3 cycles after r1 is issued -> strobes 0 and address holds 257; r2 is written to 258 the cycle after en returns.
- Clear mid-burst after r1: no writes for r2/r3, all outputs 0; next group writes r0 to 256.
- Protocol: result_valid=1 while in WRITE -> group ignored until result_ready=1, accepted exactly once.
- OUTPUT_RELU_EN defined: group 16'hFFF0/16'h0005/16'h8000/16'h7FFF -> writes 0000/0005/0000/7FFF; undefined -> values unchanged.
